// File: rtl/i2c_init_seq.sv
// i2c_init_seq: table-driven I2C configuration sequencer.
// Walks a synchronous table ROM and executes WRITE / DELAY / END entries,
// driving the single-byte I2C master through its start/busy/done handshake.
// Build macro I2C_SEQ_TIMEOUT_EN adds a per-transaction watchdog that turns a
// master stuck in REQ/WAIT for TIMEOUT_CYC cycles into an ERROR.
module i2c_init_seq #(
  parameter  int TBL_DEPTH   = 64,
  parameter  int DELAY_UNIT  = 27000,
  parameter  int TIMEOUT_CYC = 2700000,
  localparam int TBL_AW      = $clog2(TBL_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [TBL_AW-1:0] err_idx,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [16:0]       tbl_data,
  output logic              m_start,
  output logic [6:0]        m_addr,
  output logic              m_rw,
  output logic [7:0]        m_data,
  input  logic              m_busy,
  input  logic              m_done
);

  localparam int DLY_W = $clog2(255 * DELAY_UNIT + 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_REQ, S_WAIT, S_DELAY, S_NEXT, S_FINISH, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
  logic [TBL_AW-1:0] err_idx_q, err_idx_d;
  logic              seq_busy_q, seq_busy_d;
  logic              seq_done_q, seq_done_d;
  logic              seq_err_q, seq_err_d;
  logic              m_start_q, m_start_d;
  logic [6:0]        m_addr_q, m_addr_d;
  logic [7:0]        m_data_q, m_data_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              m_done_prev_q, m_done_prev_d;

  logic [1:0] op;
  logic       done_rise;
  logic       to_hit;

  assign op        = tbl_data[16:15];
  // Only a fresh rising edge of done finishes a transaction; a level left
  // high by the previous transfer must not complete the next one.
  assign done_rise = m_done & ~m_done_prev_q;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // Watchdog counts cycles spent in REQ/WAIT; zero everywhere else, so it is
  // cleared on every entry to REQ.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == S_REQ || state_q == S_WAIT) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Next-state and output decode for the script walker.
  always_comb begin
    state_d       = state_q;
    tbl_addr_d    = tbl_addr_q;
    err_idx_d     = err_idx_q;
    seq_busy_d    = seq_busy_q;
    seq_done_d    = 1'b0;
    seq_err_d     = seq_err_q;
    m_start_d     = m_start_q;
    m_addr_d      = m_addr_q;
    m_data_d      = m_data_q;
    dly_d         = dly_q;
    m_done_prev_d = m_done;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          tbl_addr_d = '0;
          seq_err_d  = 1'b0;
          seq_busy_d = 1'b1;
          state_d    = S_FETCH;
        end
      end
      // ROM has one cycle of read latency.
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_WRITE: begin
            m_addr_d  = tbl_data[14:8];
            m_data_d  = tbl_data[7:0];
            m_start_d = 1'b1;
            state_d   = S_REQ;
          end
          OP_DELAY: begin
            if (tbl_data[7:0] == 8'd0) begin
              state_d = S_NEXT;
            end else begin
              dly_d   = DLY_W'(tbl_data[7:0]) * DLY_W'(DELAY_UNIT);
              state_d = S_DELAY;
            end
          end
          OP_END:  state_d = S_FINISH;
          default: state_d = S_ERROR;
        endcase
      end
      S_REQ: begin
        if (to_hit) begin
          m_start_d = 1'b0;
          state_d   = S_ERROR;
        end else if (m_busy) begin
          m_start_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_rise) begin
          state_d = S_NEXT;
        end else if (to_hit) begin
          state_d = S_ERROR;
        end
      end
      // Stays here for exactly the loaded number of cycles.
      S_DELAY: begin
        if (dly_q <= DLY_W'(1)) begin
          dly_d   = '0;
          state_d = S_NEXT;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      // Running off the end of the table acts as an implicit END.
      S_NEXT: begin
        if (tbl_addr_q == TBL_AW'(TBL_DEPTH - 1)) begin
          state_d = S_FINISH;
        end else begin
          tbl_addr_d = tbl_addr_q + TBL_AW'(1);
          state_d    = S_FETCH;
        end
      end
      S_FINISH: begin
        seq_done_d = 1'b1;
        seq_busy_d = 1'b0;
        state_d    = S_IDLE;
      end
      S_ERROR: begin
        seq_err_d  = 1'b1;
        err_idx_d  = tbl_addr_q;
        seq_busy_d = 1'b0;
        m_start_d  = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any script immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tbl_addr_q    <= '0;
      err_idx_q     <= '0;
      seq_busy_q    <= 1'b0;
      seq_done_q    <= 1'b0;
      seq_err_q     <= 1'b0;
      m_start_q     <= 1'b0;
      m_addr_q      <= '0;
      m_data_q      <= '0;
      dly_q         <= '0;
      m_done_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tbl_addr_q    <= tbl_addr_d;
      err_idx_q     <= err_idx_d;
      seq_busy_q    <= seq_busy_d;
      seq_done_q    <= seq_done_d;
      seq_err_q     <= seq_err_d;
      m_start_q     <= m_start_d;
      m_addr_q      <= m_addr_d;
      m_data_q      <= m_data_d;
      dly_q         <= dly_d;
      m_done_prev_q <= m_done_prev_d;
    end
  end

  assign seq_busy = seq_busy_q;
  assign seq_done = seq_done_q;
  assign seq_err  = seq_err_q;
  assign err_idx  = err_idx_q;
  assign tbl_addr = tbl_addr_q;
  assign m_start  = m_start_q;
  assign m_addr   = m_addr_q;
  assign m_data   = m_data_q;
  assign m_rw     = 1'b0;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed testbench for i2c_init_seq with a table ROM and a simple master model.
// Compile with I2C_SEQ_TIMEOUT_EN defined to also exercise the watchdog.
module tb_i2c_init_seq;

  localparam int TBL_DEPTH   = 4;
  localparam int DELAY_UNIT  = 10;
  localparam int TIMEOUT_CYC = 100;
  localparam int TBL_AW      = 2;

  localparam logic [1:0] OP_W = 2'b00;
  localparam logic [1:0] OP_D = 2'b01;
  localparam logic [1:0] OP_E = 2'b10;
  localparam logic [1:0] OP_R = 2'b11;

  logic              clk;
  logic              rst_n;
  logic              go;
  logic              seq_busy;
  logic              seq_done;
  logic              seq_err;
  logic [TBL_AW-1:0] err_idx;
  logic [TBL_AW-1:0] tbl_addr;
  logic [16:0]       tbl_data;
  logic              m_start;
  logic [6:0]        m_addr;
  logic              m_rw;
  logic [7:0]        m_data;
  logic              m_busy;
  logic              m_done;

  logic [16:0] rom [TBL_DEPTH];

  int errors = 0;
  int checks = 0;

  logic mst_en;
  int   busy_cyc;
  int   done_hold;
  int   mphase = 0;
  int   mcnt = 0;
  int   done_left = 0;
  int   n_start = 0;
  int   n_done = 0;
  logic [6:0] st_addr [32];
  logic [7:0] st_data [32];
  logic       st_rw [32];
  logic [6:0] end_addr [32];
  logic [7:0] end_data [32];

  int         done_pulses = 0;
  int         start_cycles = 0;
  int         wrap_cnt = 0;
  logic       prev_busy = 1'b0;
  logic [1:0] prev_addr = 2'd0;

  i2c_init_seq #(
    .TBL_DEPTH  (TBL_DEPTH),
    .DELAY_UNIT (DELAY_UNIT),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .seq_busy(seq_busy),
    .seq_done(seq_done),
    .seq_err (seq_err),
    .err_idx (err_idx),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .m_start (m_start),
    .m_addr  (m_addr),
    .m_rw    (m_rw),
    .m_data  (m_data),
    .m_busy  (m_busy),
    .m_done  (m_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous table ROM: data valid one cycle after the address.
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // Master model: busy 3 cycles after start, busy for busy_cyc cycles, then
  // done held high for done_hold cycles (can overlap the next transaction).
  initial begin
    m_busy = 1'b0;
    m_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done_left > 0) begin
        done_left--;
        if (done_left == 0) m_done = 1'b0;
      end
      case (mphase)
        0: begin
          if (m_start && mst_en) begin
            st_addr[n_start % 32] = m_addr;
            st_data[n_start % 32] = m_data;
            st_rw[n_start % 32]   = m_rw;
            n_start++;
            mcnt   = 3;
            mphase = 1;
          end
        end
        1: begin
          mcnt--;
          if (mcnt == 0) begin
            m_busy = 1'b1;
            mcnt   = busy_cyc;
            mphase = 2;
          end
        end
        default: begin
          mcnt--;
          if (mcnt == 0) begin
            m_busy    = 1'b0;
            m_done    = 1'b1;
            done_left = done_hold;
            end_addr[n_done % 32] = m_addr;
            end_data[n_done % 32] = m_data;
            n_done++;
            mphase = 0;
          end
        end
      endcase
    end
  end

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (seq_done === 1'b1) done_pulses++;
    if (m_start === 1'b1) start_cycles++;
    if (prev_busy && seq_busy && prev_addr == 2'd3 && tbl_addr == 2'd0) wrap_cnt++;
    prev_busy = seq_busy;
    prev_addr = tbl_addr;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [16:0] mk(input logic [1:0] op, input logic [6:0] a, input logic [7:0] d);
    return {op, a, d};
  endfunction

  task automatic pulse_go;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (seq_done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int maxc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (seq_busy === 1'b0) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic settle;
    repeat (120) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    go    = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({seq_busy, seq_done, seq_err, m_start, m_rw} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {seq_busy, seq_done, seq_err, m_start, m_rw});
    end
    checks++;
    if ({err_idx, tbl_addr} !== 4'h0) begin
      errors++;
      $display("FAIL reset_idx: got %h expected 0", {err_idx, tbl_addr});
    end
    checks++;
    if ({m_addr, m_data} !== 15'h0) begin
      errors++;
      $display("FAIL reset_mdata: got %h expected 0", {m_addr, m_data});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    int s0, p0, c;
    rom[0] = mk(OP_W, 7'h3C, 8'h12);
    rom[1] = mk(OP_W, 7'h3C, 8'h34);
    rom[2] = mk(OP_E, 7'h00, 8'h00);
    rom[3] = mk(OP_E, 7'h00, 8'h00);
    busy_cyc = 200; done_hold = 1;
    s0 = n_start; p0 = done_pulses;
    pulse_go();
    checks++;
    if (seq_busy !== 1'b1) begin
      errors++;
      $display("FAIL write_busy_on_go: got %b expected 1", seq_busy);
    end
    wait_done(2000, c);
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL write_done_timeout: got none expected seq_done");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_start - s0 !== 2) begin
      errors++;
      $display("FAIL write_tx_count: got %0d expected 2", n_start - s0);
    end
    checks++;
    if ({st_addr[s0 % 32], st_data[s0 % 32], st_rw[s0 % 32]} !== {7'h3C, 8'h12, 1'b0}) begin
      errors++;
      $display("FAIL write_tx0: got %h/%h/%b expected 3c/12/0", st_addr[s0 % 32], st_data[s0 % 32], st_rw[s0 % 32]);
    end
    checks++;
    if ({st_addr[(s0 + 1) % 32], st_data[(s0 + 1) % 32], st_rw[(s0 + 1) % 32]} !== {7'h3C, 8'h34, 1'b0}) begin
      errors++;
      $display("FAIL write_tx1: got %h/%h/%b expected 3c/34/0", st_addr[(s0 + 1) % 32], st_data[(s0 + 1) % 32], st_rw[(s0 + 1) % 32]);
    end
    checks++;
    if ({end_addr[(s0 + 1) % 32], end_data[(s0 + 1) % 32]} !== {7'h3C, 8'h34}) begin
      errors++;
      $display("FAIL write_stable: got %h/%h expected 3c/34", end_addr[(s0 + 1) % 32], end_data[(s0 + 1) % 32]);
    end
    checks++;
    if (done_pulses - p0 !== 1) begin
      errors++;
      $display("FAIL write_done_pulses: got %0d expected 1", done_pulses - p0);
    end
    checks++;
    if ({seq_busy, seq_done, seq_err} !== 3'b000) begin
      errors++;
      $display("FAIL write_idle_after: got %b expected 000", {seq_busy, seq_done, seq_err});
    end
    settle();
  endtask

  task automatic test_delay;
    int s0, c0, c;
    rom[0] = mk(OP_D, 7'h00, 8'd2);
    rom[1] = mk(OP_E, 7'h00, 8'h00);
    s0 = n_start; c0 = start_cycles;
    pulse_go();
    wait_done(200, c);
    // FETCH, DECODE, 20 DELAY cycles, NEXT, FETCH, DECODE, FINISH -> pulse after edge 26
    checks++;
    if (c !== 26) begin
      errors++;
      $display("FAIL delay2_latency: got %0d expected 26", c);
    end
    checks++;
    if ((n_start - s0 !== 0) || (start_cycles - c0 !== 0)) begin
      errors++;
      $display("FAIL delay_no_start: got %0d expected 0", start_cycles - c0);
    end
    repeat (3) @(negedge clk);
    rom[0] = mk(OP_D, 7'h00, 8'd0);
    pulse_go();
    wait_done(200, c);
    checks++;
    if (c !== 6) begin
      errors++;
      $display("FAIL delay0_latency: got %0d expected 6", c);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_error;
    int s0, p0, c;
    rom[0] = mk(OP_W, 7'h50, 8'hAA);
    rom[1] = mk(OP_R, 7'h51, 8'hBB);
    rom[2] = mk(OP_W, 7'h52, 8'hCC);
    rom[3] = mk(OP_E, 7'h00, 8'h00);
    busy_cyc = 10; done_hold = 1;
    s0 = n_start; p0 = done_pulses;
    pulse_go();
    wait_idle(1000, c);
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL error_idle_timeout: got busy expected idle");
    end
    checks++;
    if ({seq_err, err_idx, seq_busy, m_start} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL error_flags: got err=%b idx=%0d busy=%b start=%b expected 1/1/0/0", seq_err, err_idx, seq_busy, m_start);
    end
    settle();
    checks++;
    if (n_start - s0 !== 1) begin
      errors++;
      $display("FAIL error_tx_count: got %0d expected 1", n_start - s0);
    end
    checks++;
    if (done_pulses - p0 !== 0) begin
      errors++;
      $display("FAIL error_no_done: got %0d expected 0", done_pulses - p0);
    end
    checks++;
    if (seq_err !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky: got %b expected 1", seq_err);
    end
    rom[0] = mk(OP_E, 7'h00, 8'h00);
    pulse_go();
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("FAIL error_clear_on_go: got %b expected 0", seq_err);
    end
    wait_done(50, c);
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL error_rerun_done: got none expected seq_done");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_no_end;
    int s0, w0, p0, c;
    rom[0] = mk(OP_W, 7'h10, 8'h01);
    rom[1] = mk(OP_W, 7'h11, 8'h02);
    rom[2] = mk(OP_W, 7'h12, 8'h03);
    rom[3] = mk(OP_W, 7'h13, 8'h04);
    busy_cyc = 5; done_hold = 1;
    s0 = n_start; w0 = wrap_cnt; p0 = done_pulses;
    pulse_go();
    wait_done(1000, c);
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL noend_done_timeout: got none expected seq_done");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_start - s0 !== 4) begin
      errors++;
      $display("FAIL noend_tx_count: got %0d expected 4", n_start - s0);
    end
    checks++;
    if ({st_addr[(s0 + 3) % 32], st_data[(s0 + 3) % 32]} !== {7'h13, 8'h04}) begin
      errors++;
      $display("FAIL noend_last_tx: got %h/%h expected 13/04", st_addr[(s0 + 3) % 32], st_data[(s0 + 3) % 32]);
    end
    checks++;
    if ((wrap_cnt - w0 !== 0) || (tbl_addr !== 2'd3)) begin
      errors++;
      $display("FAIL noend_wrap: got wraps=%0d addr=%0d expected 0/3", wrap_cnt - w0, tbl_addr);
    end
    checks++;
    if (done_pulses - p0 !== 1) begin
      errors++;
      $display("FAIL noend_done_pulses: got %0d expected 1", done_pulses - p0);
    end
    settle();
  endtask

  task automatic test_back_to_back;
    int s0, d0, p0, c, nd;
    rom[0] = mk(OP_W, 7'h3C, 8'h12);
    rom[1] = mk(OP_W, 7'h3C, 8'h34);
    rom[2] = mk(OP_E, 7'h00, 8'h00);
    rom[3] = mk(OP_E, 7'h00, 8'h00);
    busy_cyc = 80; done_hold = 50;
    s0 = n_start; d0 = n_done; p0 = done_pulses;
    pulse_go();
    repeat (3) begin
      repeat (7) @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    wait_done(1000, c);
    nd = n_done - d0;
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL b2b_done_timeout: got none expected seq_done");
    end
    checks++;
    if (nd !== 2) begin
      errors++;
      $display("FAIL b2b_completions_at_done: got %0d expected 2", nd);
    end
    settle();
    checks++;
    if (n_start - s0 !== 2) begin
      errors++;
      $display("FAIL b2b_tx_count: got %0d expected 2", n_start - s0);
    end
    checks++;
    if (done_pulses - p0 !== 1) begin
      errors++;
      $display("FAIL b2b_done_pulses: got %0d expected 1", done_pulses - p0);
    end
    done_hold = 1;
  endtask

`ifdef I2C_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int c0, c;
    rom[0] = mk(OP_W, 7'h3C, 8'h12);
    rom[1] = mk(OP_E, 7'h00, 8'h00);
    mst_en = 1'b0;
    c0 = start_cycles;
    pulse_go();
    wait_idle(400, c);
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL timeout_idle: got busy expected idle");
    end
    checks++;
    if (start_cycles - c0 !== 100) begin
      errors++;
      $display("FAIL timeout_req_cycles: got %0d expected 100", start_cycles - c0);
    end
    checks++;
    if ({seq_err, err_idx, m_start} !== {1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_flags: got err=%b idx=%0d start=%b expected 1/0/0", seq_err, err_idx, m_start);
    end
    mst_en = 1'b1;
    settle();
  endtask
`endif

  task automatic test_reset_mid;
    int c;
    rom[0] = mk(OP_W, 7'h3C, 8'h56);
    rom[1] = mk(OP_E, 7'h00, 8'h00);
    busy_cyc = 200; done_hold = 1;
    pulse_go();
    c = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_busy === 1'b1) begin
        c = i;
        break;
      end
    end
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL rstmid_busy_timeout: got none expected m_busy");
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({seq_busy, m_addr, m_data} !== {1'b1, 7'h3C, 8'h56}) begin
      errors++;
      $display("FAIL rstmid_pre: got %b/%h/%h expected 1/3c/56", seq_busy, m_addr, m_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({seq_busy, seq_done, seq_err, m_start, tbl_addr, err_idx, m_addr, m_data} !== 23'h0) begin
      errors++;
      $display("FAIL rstmid_async: got %h expected 0", {seq_busy, seq_done, seq_err, m_start, tbl_addr, err_idx, m_addr, m_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);
    checks++;
    if ({seq_busy, m_start} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_stays_idle: got %b expected 00", {seq_busy, m_start});
    end
  endtask

  initial begin
    mst_en = 1'b1;
    busy_cyc = 200;
    done_hold = 1;
    go = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < TBL_DEPTH; i++) rom[i] = mk(OP_E, 7'h00, 8'h00);
    test_reset();
    test_write();
    test_delay();
    test_error();
    test_no_end();
    test_back_to_back();
`ifdef I2C_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
